// File: rtl/smp_ctrl.sv
// rtl/smp_ctrl.sv - multi-core run/halt/step controller with counted stepping and breakpoint cross-trigger
module smp_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int BSP_INDEX = 0,
  parameter int STEP_W    = 8,
  localparam int AW       = $clog2(NUM_CORES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        address,
  input  logic                 write,
  input  logic [31:0]          writedata,
  input  logic                 read,
  output logic [31:0]          readdata,
  input  logic [NUM_CORES-1:0] cpu_alive,
  input  logic [NUM_CORES-1:0] cpu_halted,
  input  logic [NUM_CORES-1:0] breakpoint,
  input  logic [NUM_CORES-1:0] cpu_retire,
  output logic [NUM_CORES-1:0] halt,
  output logic [NUM_CORES-1:0] step
);

  localparam logic [1:0] ST_HALTED = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;

  logic [1:0]           state_q [NUM_CORES];
  logic [1:0]           state_d [NUM_CORES];
  logic [STEP_W-1:0]    count_q [NUM_CORES];
  logic [STEP_W-1:0]    count_d [NUM_CORES];
  logic [NUM_CORES-1:0] sticky_q, sticky_d;
  logic [NUM_CORES-1:0] xtrig_en_q, xtrig_en_d;
  logic [NUM_CORES-1:0] halted_q;
  logic [NUM_CORES-1:0] halt_q, halt_d;
  logic [NUM_CORES-1:0] step_q, step_d;
  logic                 xtrig_pending_q, xtrig_pending_d;
  logic [31:0]          readdata_q, readdata_d;

  logic                 g_wr, g_halt, g_run, g_cmd;
  logic [STEP_W-1:0]    step_n;
  logic [NUM_CORES-1:0] core_wr, core_cmd, active;
  logic                 unused_wd;

  assign unused_wd = ^writedata;

  always_comb begin
    g_wr   = write && (address == AW'(NUM_CORES));
    g_halt = g_wr && writedata[1];
    g_run  = g_wr && writedata[0] && !writedata[1];
    g_cmd  = g_halt || g_run;
    step_n = (writedata[16 +: STEP_W] == '0) ? STEP_W'(1) : writedata[16 +: STEP_W];
    xtrig_pending_d = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      core_wr[i]    = write && (address == AW'(i));
      core_cmd[i]   = core_wr[i] && (writedata[0] || writedata[1] || writedata[2]);
      active[i]     = (state_q[i] == ST_RUN) || (state_q[i] == ST_STEP);
      state_d[i]    = state_q[i];
      count_d[i]    = count_q[i];
      sticky_d[i]   = sticky_q[i];
      xtrig_en_d[i] = xtrig_en_q[i];

      if (breakpoint[i] && active[i] && xtrig_en_q[i] && !g_cmd) xtrig_pending_d = 1'b1;

      // Global command > core command > breakpoint/cross-halt > retire
      if (g_halt) begin
        state_d[i] = ST_HALTED;
      end else if (g_run) begin
        state_d[i] = ST_RUN;
      end else if (core_cmd[i]) begin
        if (writedata[1]) begin
          state_d[i] = ST_HALTED;
        end else if (writedata[2]) begin
          state_d[i] = ST_STEP;
          count_d[i] = step_n;
        end else begin
          state_d[i] = ST_RUN;
        end
      end else if (active[i] && (breakpoint[i] || xtrig_pending_q)) begin
        state_d[i] = ST_HALTED;
      end else if ((state_q[i] == ST_STEP) && cpu_retire[i]) begin
        if (count_q[i] <= STEP_W'(1)) begin
          state_d[i] = ST_HALTED;
          count_d[i] = '0;
        end else begin
          count_d[i] = count_q[i] - STEP_W'(1);
        end
      end

      if (g_run) begin
        sticky_d[i] = 1'b0;
      end else begin
        if ((core_cmd[i] && !writedata[1]) || (core_wr[i] && writedata[5])) sticky_d[i] = 1'b0;
        if (breakpoint[i]) sticky_d[i] = 1'b1;
      end

      if (core_wr[i] && writedata[7]) xtrig_en_d[i] = writedata[6];

      halt_d[i] = (state_d[i] == ST_HALTED);
      step_d[i] = (state_d[i] == ST_STEP);
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (read) begin
      readdata_d = '0;
      if (address == AW'(NUM_CORES)) begin
        for (int i = 0; i < NUM_CORES; i++) begin
          readdata_d[i]      = halt_q[i];
          readdata_d[16 + i] = sticky_q[i];
        end
      end else begin
        for (int i = 0; i < NUM_CORES; i++) begin
          if (address == AW'(i)) begin
            readdata_d[0]             = cpu_alive[i];
            readdata_d[1]             = halted_q[i];
            readdata_d[2]             = sticky_q[i];
            readdata_d[3]             = halt_q[i];
            readdata_d[4]             = step_q[i];
            readdata_d[6]             = xtrig_en_q[i];
            readdata_d[16 +: STEP_W]  = count_q[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        state_q[i] <= (i == BSP_INDEX) ? ST_RUN : ST_HALTED;
        count_q[i] <= '0;
        halt_q[i]  <= (i != BSP_INDEX);
        step_q[i]  <= 1'b0;
      end
      sticky_q        <= '0;
      xtrig_en_q      <= '0;
      halted_q        <= '0;
      xtrig_pending_q <= 1'b0;
      readdata_q      <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
      halt_q          <= halt_d;
      step_q          <= step_d;
      sticky_q        <= sticky_d;
      xtrig_en_q      <= xtrig_en_d;
      halted_q        <= cpu_halted;
      xtrig_pending_q <= xtrig_pending_d;
      readdata_q      <= readdata_d;
    end
  end

  assign halt     = halt_q;
  assign step     = step_q;
  assign readdata = readdata_q;

endmodule

// File: tb/tb_smp_ctrl.sv
// tb/tb_smp_ctrl.sv - directed and randomized checks of smp_ctrl against a behavioural model
module tb_smp_ctrl;
  localparam int NC = 4;
  localparam int SW = 8;
  localparam int AW = $clog2(NC + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] address = '0;
  logic          write = 1'b0;
  logic [31:0]   writedata = '0;
  logic          read = 1'b0;
  logic [31:0]   readdata;
  logic [NC-1:0] cpu_alive = '1;
  logic [NC-1:0] cpu_halted = '0;
  logic [NC-1:0] breakpoint = '0;
  logic [NC-1:0] cpu_retire = '0;
  logic [NC-1:0] halt;
  logic [NC-1:0] step;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 = halted, 1 = running, 2 = stepping
  int          mode [NC];
  int          cnt  [NC];
  bit          stk  [NC];
  bit          xen  [NC];
  bit          hs   [NC];
  bit          pend;
  logic [31:0] rd_m;

  smp_ctrl #(.NUM_CORES(NC), .BSP_INDEX(0), .STEP_W(SW)) dut (
    .clk(clk), .rst(rst), .address(address), .write(write), .writedata(writedata),
    .read(read), .readdata(readdata), .cpu_alive(cpu_alive), .cpu_halted(cpu_halted),
    .breakpoint(breakpoint), .cpu_retire(cpu_retire), .halt(halt), .step(step)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(int a);
    logic [31:0] r;
    r = '0;
    if (a == NC) begin
      for (int i = 0; i < NC; i++) begin
        r[i]      = (mode[i] == 0);
        r[16 + i] = stk[i];
      end
    end else if (a < NC) begin
      r    = 32'(cnt[a]) << 16;
      r[0] = cpu_alive[a];
      r[1] = hs[a];
      r[2] = stk[a];
      r[3] = (mode[a] == 0);
      r[4] = (mode[a] == 2);
      r[6] = xen[a];
    end
    return r;
  endfunction

  function automatic logic [NC-1:0] model_mask(int m);
    logic [NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i] = (mode[i] == m);
    return v;
  endfunction

  task automatic model_cycle();
    int  nmode [NC];
    int  ncnt  [NC];
    int  n;
    bit  npend, gw, ghalt, grun;
    if (rst) begin
      for (int i = 0; i < NC; i++) begin
        mode[i] = (i == 0) ? 1 : 0;
        cnt[i]  = 0;
        stk[i]  = 0;
        xen[i]  = 0;
        hs[i]   = 0;
      end
      pend = 0;
      rd_m = '0;
      return;
    end
    if (read) rd_m = model_read(int'(address));
    gw    = write && (int'(address) == NC);
    ghalt = gw && writedata[1];
    grun  = gw && writedata[0] && !writedata[1];
    n     = int'(writedata[23:16]);
    npend = 0;
    for (int i = 0; i < NC; i++) begin
      bit cw, cmd, live;
      cw       = write && (int'(address) == i);
      cmd      = cw && (writedata[2:0] != 3'b000);
      live     = (mode[i] != 0);
      nmode[i] = mode[i];
      ncnt[i]  = cnt[i];
      if (live && breakpoint[i] && xen[i] && !ghalt && !grun) npend = 1;
      if (ghalt) nmode[i] = 0;
      else if (grun) nmode[i] = 1;
      else if (cmd) begin
        if (writedata[1]) nmode[i] = 0;
        else if (writedata[2]) begin
          nmode[i] = 2;
          ncnt[i]  = (n == 0) ? 1 : n;
        end else nmode[i] = 1;
      end else if (live && (breakpoint[i] || pend)) nmode[i] = 0;
      else if (mode[i] == 2 && cpu_retire[i]) begin
        ncnt[i] = cnt[i] - 1;
        if (ncnt[i] <= 0) begin
          nmode[i] = 0;
          ncnt[i]  = 0;
        end
      end
      if (grun) stk[i] = 0;
      else begin
        if ((cmd && !writedata[1]) || (cw && writedata[5])) stk[i] = 0;
        if (breakpoint[i]) stk[i] = 1;
      end
      if (cw && writedata[7]) xen[i] = writedata[6];
      hs[i] = cpu_halted[i];
    end
    mode = nmode;
    cnt  = ncnt;
    pend = npend;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    check("model_halt", 32'(halt), 32'(model_mask(0)));
    check("model_step", 32'(step), 32'(model_mask(2)));
    check("model_readdata", readdata, rd_m);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    address   = AW'(a);
    writedata = d;
    write     = 1'b1;
    tick();
    write     = 1'b0;
  endtask

  task automatic rd(input int a);
    address = AW'(a);
    read    = 1'b1;
    tick();
    read    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_halt", 32'(halt), 32'h0000_000E);
    check("reset_step", 32'(step), 32'h0);
    check("reset_readdata", readdata, 32'h0);
    rd(NC);
    check("reset_global_read", readdata, 32'h0000_000E);

    wr(2, 32'h0003_0004);
    check("cstep_step", 32'(step), 32'h4);
    check("cstep_halt", 32'(halt), 32'hA);
    cpu_retire = 4'b0100;
    tick();
    tick();
    check("cstep_mid_step", 32'(step), 32'h4);
    tick();
    cpu_retire = '0;
    check("cstep_done_halt", 32'(halt), 32'hE);
    check("cstep_done_step", 32'(step), 32'h0);
    rd(2);
    check("cstep_count", 32'(readdata[23:16]), 32'h0);
    check("cstep_core_read", readdata, 32'h0000_0009);

    wr(NC, 32'h1);
    check("runall_halt", 32'(halt), 32'h0);
    wr(1, 32'hC0);
    breakpoint = 4'b0010;
    tick();
    breakpoint = '0;
    check("xtrig_first", 32'(halt), 32'h2);
    tick();
    check("xtrig_all", 32'(halt), 32'hF);
    rd(NC);
    check("xtrig_global_read", readdata, 32'h0002_000F);

    wr(NC, 32'h1);
    address    = AW'(3);
    writedata  = 32'h1;
    write      = 1'b1;
    breakpoint = 4'b1000;
    tick();
    write      = 1'b0;
    breakpoint = '0;
    check("prio_run", 32'(halt), 32'h0);
    rd(3);
    check("prio_sticky", readdata, 32'h0000_0005);
    wr(3, 32'h1);
    rd(3);
    check("prio_clear", readdata, 32'h0000_0001);

    wr(0, 32'h4);
    check("n0_step", 32'(step), 32'h1);
    cpu_retire = 4'b0001;
    tick();
    cpu_retire = '0;
    check("n0_halt", 32'(halt), 32'h1);
    check("n0_step_off", 32'(step), 32'h0);
    wr(NC + 1, 32'h0000_0003);
    check("oor_write_halt", 32'(halt), 32'h1);
    rd(NC + 1);
    check("oor_read", readdata, 32'h0);

    wr(1, (32'd200 << 16) | 32'h4);
    check("rstmid_step", 32'(step), 32'h2);
    cpu_retire = 4'b0010;
    repeat (5) tick();
    cpu_retire = '0;
    rd(1);
    check("rstmid_count", 32'(readdata[23:16]), 32'd195);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rstmid_halt", 32'(halt), 32'hE);
    check("rstmid_step_off", 32'(step), 32'h0);
    rd(1);
    check("rstmid_core_read", readdata, 32'h0000_0009);

    // Random traffic with small step counts so steps complete often
    for (int c = 0; c < 800; c++) begin
      rst        = ($urandom_range(0, 199) == 0);
      write      = ($urandom_range(0, 3) == 0);
      read       = $urandom_range(0, 1);
      address    = AW'($urandom_range(0, 7));
      writedata  = $urandom;
      writedata[23:16] = 8'($urandom_range(0, 4));
      for (int i = 0; i < NC; i++) breakpoint[i] = ($urandom_range(0, 19) == 0);
      cpu_retire = NC'($urandom);
      cpu_alive  = NC'($urandom);
      cpu_halted = NC'($urandom);
      tick();
    end
    rst = 1'b0;
    write = 1'b0;
    read = 1'b0;
    breakpoint = '0;
    cpu_retire = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
